// File: rtl/multicycle_core_pkg.sv
// Shared types and the instruction decoder for the multi-cycle RV32I core.
// decode() maps one instruction word to the control fields used by every other stage.
package multicycle_core_pkg;

  typedef enum logic [2:0] {
    FETCH, REGREAD, EXECUTE, MEMORY, WRITEBACK, HALT
  } t_core_state;

  typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD} t_memory_width;

  typedef enum logic [1:0] {BRANCH_NONE, BRANCH_NE, BRANCH_EQ, BRANCH_JAL} t_branch_condition;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } t_alu_op;

  typedef struct packed {
    t_alu_op           alu_op;
    logic              use_imm;
    logic [31:0]       imm;
    logic              rd_enable;
    logic              memory_read_enable;
    logic              memory_write_enable;
    t_memory_width     memory_width;
    logic              memory_unsigned;
    t_branch_condition branch;
  } t_decoded;

  function automatic t_alu_op alu_from_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic t_decoded decode(input logic [31:0] instr);
    t_decoded d;
    d = '0;
    d.imm = {{20{instr[31]}}, instr[31:20]};
    case (instr[13:12])
      2'b00:   d.memory_width = MEM_BYTE;
      2'b01:   d.memory_width = MEM_HALF;
      default: d.memory_width = MEM_WORD;
    endcase
    d.memory_unsigned = instr[14];
    case (instr[6:0])
      7'b0010011: begin  // OP-IMM: only shifts carry the funct7 alternate bit
        d.use_imm   = 1'b1;
        d.rd_enable = 1'b1;
        d.alu_op    = alu_from_funct(instr[14:12], instr[30] & (instr[14:12] == 3'b101));
      end
      7'b0110011: begin
        d.rd_enable = 1'b1;
        d.alu_op    = alu_from_funct(instr[14:12], instr[30]);
      end
      7'b0110111: begin
        d.use_imm   = 1'b1;
        d.rd_enable = 1'b1;
        d.imm       = {instr[31:12], 12'b0};
        d.alu_op    = ALU_PASS_B;
      end
      7'b0000011: begin
        d.use_imm            = 1'b1;
        d.rd_enable          = 1'b1;
        d.memory_read_enable = 1'b1;
      end
      7'b0100011: begin
        d.use_imm             = 1'b1;
        d.memory_write_enable = 1'b1;
        d.imm                 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        d.alu_op = ALU_SUB;
        d.imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        case (instr[14:12])
          3'b000:  d.branch = BRANCH_EQ;
          3'b001:  d.branch = BRANCH_NE;
          default: d.branch = BRANCH_NONE;
        endcase
      end
      7'b1101111: begin
        d.rd_enable = 1'b1;
        d.branch    = BRANCH_JAL;
        d.imm       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_core_load_store_unit.sv
// Combinational data-side helper: alignment check, byte lanes, store replication, load extraction.
// Misaligned offsets are forced down to the access width so the non-trapping build keeps running.
module load_store_unit
  import multicycle_core_pkg::*;
(
  input  logic [31:0]   i_address,
  input  t_memory_width i_width,
  input  logic          i_unsigned,
  input  logic [31:0]   i_store_data,
  input  logic [31:0]   i_load_word,
  output logic          o_misaligned,
  output logic [31:0]   o_word_address,
  output logic [3:0]    o_byte_enable,
  output logic [31:0]   o_store_data,
  output logic [31:0]   o_load_data
);
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign o_word_address = {i_address[31:2], 2'b00};

  always_comb begin
    case (i_address[1:0])
      2'd0:    lane_byte = i_load_word[7:0];
      2'd1:    lane_byte = i_load_word[15:8];
      2'd2:    lane_byte = i_load_word[23:16];
      default: lane_byte = i_load_word[31:24];
    endcase
    lane_half = i_address[1] ? i_load_word[31:16] : i_load_word[15:0];
  end

  always_comb begin
    o_misaligned  = 1'b0;
    o_byte_enable = 4'b1111;
    o_store_data  = i_store_data;
    o_load_data   = i_load_word;
    case (i_width)
      MEM_BYTE: begin
        o_byte_enable = 4'b0001 << i_address[1:0];
        o_store_data  = {4{i_store_data[7:0]}};
        o_load_data   = {{24{~i_unsigned & lane_byte[7]}}, lane_byte};
      end
      MEM_HALF: begin
        o_misaligned  = i_address[0];
        o_byte_enable = i_address[1] ? 4'b1100 : 4'b0011;
        o_store_data  = {2{i_store_data[15:0]}};
        o_load_data   = {{16{~i_unsigned & lane_half[15]}}, lane_half};
      end
      default: o_misaligned = |i_address[1:0];
    endcase
  end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I core: FETCH -> REGREAD -> EXECUTE -> [MEMORY] -> WRITEBACK, HALT on trap.
// Handshakes: a request stays high and its payload stable until the matching valid/ack is seen on a rising edge; valid/ack outside FETCH/MEMORY are ignored.
module multicycle_core
  import multicycle_core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
  parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  output logic        o_instr_req,
  output logic [31:0] o_instr_address,
  input  logic        i_instr_valid,
  input  logic [31:0] i_instruction,
  output logic        o_data_req,
  output logic        o_data_we,
  output logic [3:0]  o_data_byte_enable,
  output logic [31:0] o_data_address,
  output logic [31:0] o_data_wdata,
  input  logic        i_data_ack,
  input  logic [31:0] i_data_rdata,
  output logic        o_retire,
  output logic        o_trap,
  output t_core_state o_debug_state
);
  t_core_state state, state_next;
  t_decoded    dec;
  logic [31:0] pc, instr, rs1_value, rs2_value, alu_result, load_data;
  logic [31:0] regs [32];
  logic [31:0] operand_b, alu_out, pc_plus4, next_pc_raw, next_pc, wb_data;
  logic [31:0] lsu_address, lsu_wdata, lsu_load_data;
  logic [3:0]  lsu_byte_enable;
  logic        lsu_misaligned, branch_taken, in_memory;
  logic [4:0]  rs1, rs2, rd;

  assign dec = decode(instr);
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];

  always_comb begin
    operand_b = dec.use_imm ? dec.imm : rs2_value;
    alu_out   = rs1_value + operand_b;
    case (dec.alu_op)
      ALU_SUB:    alu_out = rs1_value - operand_b;
      ALU_SLL:    alu_out = rs1_value << operand_b[4:0];
      ALU_SLT:    alu_out = {31'b0, $signed(rs1_value) < $signed(operand_b)};
      ALU_SLTU:   alu_out = {31'b0, rs1_value < operand_b};
      ALU_XOR:    alu_out = rs1_value ^ operand_b;
      ALU_SRL:    alu_out = rs1_value >> operand_b[4:0];
      ALU_SRA:    alu_out = $unsigned($signed(rs1_value) >>> operand_b[4:0]);
      ALU_OR:     alu_out = rs1_value | operand_b;
      ALU_AND:    alu_out = rs1_value & operand_b;
      ALU_PASS_B: alu_out = operand_b;
      default: ;
    endcase
  end

  // Operands are held through MEMORY, so the live ALU output is the access address there too.
  load_store_unit u_lsu (
    .i_address     (alu_out),
    .i_width       (dec.memory_width),
    .i_unsigned    (dec.memory_unsigned),
    .i_store_data  (rs2_value),
    .i_load_word   (i_data_rdata),
    .o_misaligned  (lsu_misaligned),
    .o_word_address(lsu_address),
    .o_byte_enable (lsu_byte_enable),
    .o_store_data  (lsu_wdata),
    .o_load_data   (lsu_load_data)
  );

  always_comb begin
    pc_plus4     = pc + 32'd4;
    branch_taken = 1'b0;
    case (dec.branch)
      BRANCH_JAL: branch_taken = 1'b1;
      BRANCH_NE:  branch_taken = |alu_result;
      BRANCH_EQ:  branch_taken = ~|alu_result;
      default: ;
    endcase
    next_pc_raw = branch_taken ? pc + dec.imm : pc_plus4;
    next_pc     = TRAP_ON_MISALIGN ? next_pc_raw : {next_pc_raw[31:2], 2'b00};
    if (dec.memory_read_enable) wb_data = load_data;
    else if (dec.branch == BRANCH_JAL) wb_data = pc_plus4;
    else wb_data = alu_result;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:     if (i_instr_valid) state_next = REGREAD;
      REGREAD:   state_next = EXECUTE;
      EXECUTE: begin
        if (dec.memory_read_enable || dec.memory_write_enable)
          state_next = (TRAP_ON_MISALIGN && lsu_misaligned) ? HALT : MEMORY;
        else
          state_next = WRITEBACK;
      end
      MEMORY:    if (i_data_ack) state_next = WRITEBACK;
      WRITEBACK: state_next = (TRAP_ON_MISALIGN && next_pc_raw[1:0] != 2'b00) ? HALT : FETCH;
      HALT:      state_next = HALT;
      default:   state_next = FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= FETCH;
      pc         <= RESET_VECTOR;
      instr      <= 32'h0;
      rs1_value  <= 32'h0;
      rs2_value  <= 32'h0;
      alu_result <= 32'h0;
      load_data  <= 32'h0;
    end else begin
      state <= state_next;
      case (state)
        FETCH:     if (i_instr_valid) instr <= i_instruction;
        REGREAD: begin
          rs1_value <= (rs1 == 5'd0) ? 32'h0 : regs[rs1];
          rs2_value <= (rs2 == 5'd0) ? 32'h0 : regs[rs2];
        end
        EXECUTE:   alu_result <= alu_out;
        MEMORY:    if (i_data_ack) load_data <= lsu_load_data;
        WRITEBACK: pc <= next_pc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == WRITEBACK && dec.rd_enable && rd != 5'd0) regs[rd] <= wb_data;
  end

  assign in_memory          = (state == MEMORY);
  assign o_instr_req        = (state == FETCH);
  assign o_instr_address    = pc;
  assign o_data_req         = in_memory;
  assign o_data_we          = in_memory & dec.memory_write_enable;
  assign o_data_byte_enable = in_memory ? lsu_byte_enable : 4'b0000;
  assign o_data_address     = in_memory ? lsu_address : 32'h0;
  assign o_data_wdata       = o_data_we ? lsu_wdata : 32'h0;
  assign o_retire           = (state == WRITEBACK);
  assign o_trap             = (state == HALT);
  assign o_debug_state      = state;

endmodule
